maxnet_winner_monitor: RTL and testbench
========================================

# maxnet_winner_monitor

Parametrised convergence monitor for the Maxnet iteration loop. Each cycle the loop presents N activations and N payload words; the block flags a channel as non-zero when its magnitude is non-zero and tracks how many remain. It declares a result once exactly one channel has survived for a programmable number of consecutive samples, when all channels collapse to zero, or when an iteration budget runs out. The result (winner index, payload, status, iteration count) is held on a valid/ready output port until the consumer accepts it.

## Interface
- N, 4, channel count (≥2)
- W, 32, word width of each activation and payload
- IGNORE_SIGN, 1, 1: zero test ignores bit W-1 (IEEE ±0 both zero); 0: all W bits tested
- STABLE, 2, consecutive single-survivor samples (same index) required to converge (≥1)
- MAX_ITER, 255, accepted-sample budget before timeout (≥1)
- Derived: IW = max(1, clog2(N)); CW = clog2(MAX_ITER+1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new run (honoured in IDLE only)
- in_valid  in  1  x_bus/a_bus hold one iteration's sample
- in_ready  out  1  high exactly while in RUN
- x_bus  in  N*W  activations, channel i at [i*W +: W]
- a_bus  in  N*W  payloads, channel i at [i*W +: W]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- winner_idx  out  IW  surviving channel index
- winner_data  out  W  payload of surviving channel
- status  out  2  00 converged, 01 all-zero, 10 timeout
- iter_count  out  CW  accepted samples in this run
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN; iter_count, stable_cnt, prev_idx cleared.
- RUN: sample accepted when in_valid && in_ready. Per accepted sample: nz[i] = |x_i[W-2:0] (IGNORE_SIGN=1) or |x_i; pop = popcount(nz); cand = lowest i with nz[i]=1 (0 if none); iter_count += 1.
- stable_cnt: pop==1 and (stable_cnt==0 or cand==prev_idx) → +1 (saturating at STABLE); pop==1 with different cand → 1; pop≥2 → 0. prev_idx ← cand.
- Termination, priority order on the same sample: pop==0 → status 01; next stable_cnt==STABLE → 00; next iter_count==MAX_ITER → 10. Otherwise stay in RUN.
- On termination: winner_idx ← cand, winner_data ← a_cand (channel 0 payload for all-zero), status and iter_count latched; → DONE.
- DONE: out_valid=1, all outputs frozen; out_valid && out_ready → IDLE.
- start outside IDLE ignored. in_valid outside RUN ignored (no count change).
- Reset at any point: IDLE; out_valid, in_ready, busy, winner_idx, winner_data, status, iter_count, internal counters all 0.

## Timing
- start sampled in IDLE → in_ready=1 and busy=1 from next cycle.
- Terminating sample accepted at edge k → out_valid=1 after edge k, in_ready=0 same cycle; latency 1 cycle.
- Handshake at edge m → out_valid=0, busy=0 after edge m; start earliest honoured at edge m+1.
- Output fields stable for the whole time out_valid=1; out_ready may be held high permanently (result visible exactly one cycle).
- Fastest run: STABLE=1, first sample single survivor → out_valid one cycle after that sample.
- No combinational path from in_valid/x_bus/a_bus to any output; in_ready depends on state only.

## Test plan
- N=4, STABLE=2: samples {5,3,0,0}, {2,0,0,0}, {1,0,0,0} → out_valid after 3rd sample, winner_idx=0, status=00, iter_count=3, winner_data=a0.
- IGNORE_SIGN=1: x={0x80000000,0,0x3F800000,0} twice → channel 0 counts zero; winner_idx=2, status=00, iter_count=2.
- All-zero: first sample {0,0x80000000,0,0} → status=01, winner_idx=0, winner_data=a0, iter_count=1.
- Survivor switch: {0,7,0,0}, {0,0,4,0}, {0,0,4,0} with STABLE=2 → no result after 2nd; result after 3rd, winner_idx=2, iter_count=3.
- Timeout: MAX_ITER=5, five samples with ≥2 non-zero channels → status=10, iter_count=5, winner_idx=lowest non-zero index; if the 5th sample also completes STABLE, status=00.
- Back-pressure and reset: hold out_ready=0 for 10 cycles → outputs frozen, start ignored; drop rst_n mid-RUN → all outputs 0 immediately, IDLE; new start runs normally.

Source files
------------

// File: rtl/maxnet_winner_monitor.sv
// Maxnet convergence monitor: picks the single surviving channel, all-zero collapse, or iteration timeout.
// Latency: result registered one cycle after the terminating sample is accepted.
// Backpressure: in_ready only in RUN; result held on out_valid until out_ready, then back to IDLE.
module maxnet_winner_monitor #(
  parameter int N           = 4,
  parameter int W           = 32,
  parameter int IGNORE_SIGN = 1,
  parameter int STABLE      = 2,
  parameter int MAX_ITER    = 255,
  localparam int IW         = (N > 2) ? $clog2(N) : 1,
  localparam int CW         = $clog2(MAX_ITER + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  x_bus,
  input  logic [N*W-1:0]  a_bus,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   winner_idx,
  output logic [W-1:0]    winner_data,
  output logic [1:0]      status,
  output logic [CW-1:0]   iter_count,
  output logic            busy
);

  localparam int SW = $clog2(STABLE + 1);
  localparam int PW = $clog2(N + 1);
  localparam logic [W-1:0] ZMASK = (IGNORE_SIGN != 0) ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  dat;
    logic [1:0]    st;
  } res_t;

  state_t        state, state_nxt;
  res_t          res_q;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic [IW-1:0] prev_idx;
  logic [CW-1:0] iter_nxt;
  logic [N-1:0]  nz;
  logic [PW-1:0] pop;
  logic [IW-1:0] cand;
  logic [W-1:0]  cand_dat;
  logic          accept, all_zero, conv, tmo, term;

  // Descending scan so the lowest non-zero channel wins; with no survivor cand stays 0 and payload a0.
  always_comb begin
    nz       = '0;
    pop      = '0;
    cand     = '0;
    cand_dat = a_bus[W-1:0];
    for (int i = N - 1; i >= 0; i--) begin
      nz[i] = |(x_bus[i*W +: W] & ZMASK);
      if (nz[i]) begin
        cand     = IW'(i);
        cand_dat = a_bus[i*W +: W];
      end
    end
    for (int i = 0; i < N; i++) pop = pop + PW'(nz[i]);
  end

  always_comb begin
    stable_nxt = '0;
    if (pop == PW'(1)) begin
      if (stable_cnt == '0 || cand == prev_idx)
        stable_nxt = (stable_cnt == SW'(STABLE)) ? stable_cnt : stable_cnt + SW'(1);
      else
        stable_nxt = SW'(1);
    end
  end

  assign iter_nxt = iter_count + CW'(1);
  assign accept   = in_valid && (state == S_RUN);
  assign all_zero = (pop == '0);
  assign conv     = (stable_nxt == SW'(STABLE));
  assign tmo      = (iter_nxt == CW'(MAX_ITER));
  assign term     = accept && (all_zero || conv || tmo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_RUN;
      S_RUN:   if (term)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_RUN);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_count <= '0;
      stable_cnt <= '0;
      prev_idx   <= '0;
      res_q      <= '0;
    end else if (state == S_IDLE && start) begin
      iter_count <= '0;
      stable_cnt <= '0;
      prev_idx   <= '0;
    end else if (accept) begin
      iter_count <= iter_nxt;
      stable_cnt <= stable_nxt;
      prev_idx   <= cand;
      if (term) begin
        res_q.idx <= cand;
        res_q.dat <= cand_dat;
        res_q.st  <= all_zero ? 2'b01 : (conv ? 2'b00 : 2'b10);
      end
    end
  end

  assign winner_idx  = res_q.idx;
  assign winner_data = res_q.dat;
  assign status      = res_q.st;

endmodule

// File: tb/tb_maxnet_winner_monitor.sv
// Randomized and directed bench for maxnet_winner_monitor (N=4, W=32, STABLE=2, MAX_ITER=5).
module tb_maxnet_winner_monitor;
  localparam int N = 4;
  localparam int W = 32;
  localparam int STABLE = 2;
  localparam int MAX_ITER = 5;
  typedef logic [N*W-1:0] bus_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  bus_t x_bus = '0, a_bus = '0;
  logic [1:0]   winner_idx;
  logic [W-1:0] winner_data;
  logic [1:0]   status;
  logic [2:0]   iter_count;
  int total = 0;
  int bad = 0;

  maxnet_winner_monitor #(.N(N), .W(W), .IGNORE_SIGN(1), .STABLE(STABLE), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x_bus(x_bus), .a_bus(a_bus), .out_valid(out_valid), .out_ready(out_ready),
    .winner_idx(winner_idx), .winner_data(winner_data), .status(status),
    .iter_count(iter_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic bus_t mk(input logic [31:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Start a run and feed samples until a result appears; done_at = 1-based sample count, 0 if none.
  task automatic run_seq(input bus_t xs[$], input bus_t as[$], input bit rnd, output int done_at);
    start = 1'b1;
    step();
    start = 1'b0;
    done_at = 0;
    for (int k = 0; k < xs.size(); k++) begin
      if (done_at == 0) begin
        if (rnd && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          x_bus = {$urandom, $urandom, $urandom, $urandom};
          step();
        end
        in_valid = 1'b1;
        x_bus = xs[k];
        a_bus = as[k];
        start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        in_valid = 1'b0;
        start = 1'b0;
        if (out_valid) done_at = k + 1;
      end
    end
  endtask

  task automatic accept;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Reference: result decided from run length of consecutive same-index single survivors.
  task automatic model(input bus_t xs[$], input bus_t as[$], output int n, output int st,
                       output int idx, output logic [31:0] dat);
    int run, last, cnt, low;
    bus_t t;
    n = 0; st = 0; idx = 0; dat = '0; run = 0; last = -1;
    for (int k = 0; k < xs.size() && n == 0; k++) begin
      t = xs[k];
      cnt = 0; low = -1;
      for (int c = N - 1; c >= 0; c--)
        if ((t[c*W +: W] & 32'h7FFF_FFFF) != 0) begin cnt++; low = c; end
      if (cnt == 1) begin
        run = (run > 0 && low == last) ? run + 1 : 1;
        last = low;
      end else run = 0;
      if (cnt == 0) begin n = k + 1; st = 1; idx = 0; end
      else if (run == STABLE) begin n = k + 1; st = 0; idx = low; end
      else if (k + 1 == MAX_ITER) begin n = k + 1; st = 2; idx = low; end
      if (n != 0) begin t = as[k]; dat = t[idx*W +: W]; end
    end
  endtask

  task automatic test_reset;
    total++;
    if ({out_valid, in_ready, busy, winner_idx, winner_data, status, iter_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ov=%b ir=%b busy=%b idx=%0d dat=%h st=%b it=%0d want all 0",
               out_valid, in_ready, busy, winner_idx, winner_data, status, iter_count);
    end
  endtask

  task automatic test_converge;
    bus_t xs[$], as[$];
    int d;
    xs = '{mk(5, 3, 0, 0), mk(2, 0, 0, 0), mk(1, 0, 0, 0)};
    as = '{mk(11, 12, 13, 14), mk(21, 22, 23, 24), mk(31, 32, 33, 34)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 3) begin bad++; $display("FAIL conv_done_at got=%0d want=3", d); end
    total++; if (winner_idx !== 2'd0) begin bad++; $display("FAIL conv_idx got=%0d want=0", winner_idx); end
    total++; if (status !== 2'b00) begin bad++; $display("FAIL conv_status got=%b want=00", status); end
    total++; if (iter_count !== 3'd3) begin bad++; $display("FAIL conv_iter got=%0d want=3", iter_count); end
    total++; if (winner_data !== 32'd31) begin bad++; $display("FAIL conv_data got=%0d want=31", winner_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL conv_in_ready got=%b want=0", in_ready); end
    accept();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL conv_release got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_ignore_sign;
    bus_t xs[$], as[$];
    int d;
    xs = '{mk(32'h8000_0000, 0, 32'h3F80_0000, 0), mk(32'h8000_0000, 0, 32'h3F80_0000, 0)};
    as = '{mk(1, 2, 3, 4), mk(5, 6, 7, 8)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 2) begin bad++; $display("FAIL sign_done_at got=%0d want=2", d); end
    total++; if (winner_idx !== 2'd2) begin bad++; $display("FAIL sign_idx got=%0d want=2", winner_idx); end
    total++; if (status !== 2'b00 || iter_count !== 3'd2 || winner_data !== 32'd7) begin
      bad++; $display("FAIL sign_fields got st=%b it=%0d dat=%0d want 00 2 7", status, iter_count, winner_data);
    end
    accept();
  endtask

  task automatic test_all_zero;
    bus_t xs[$], as[$];
    int d;
    xs = '{mk(0, 32'h8000_0000, 0, 0)};
    as = '{mk(77, 78, 79, 80)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 1) begin bad++; $display("FAIL zero_done_at got=%0d want=1", d); end
    total++; if (status !== 2'b01) begin bad++; $display("FAIL zero_status got=%b want=01", status); end
    total++; if (winner_idx !== 2'd0 || winner_data !== 32'd77 || iter_count !== 3'd1) begin
      bad++; $display("FAIL zero_fields got idx=%0d dat=%0d it=%0d want 0 77 1", winner_idx, winner_data, iter_count);
    end
    accept();
  endtask

  task automatic test_switch;
    bus_t xs[$], as[$];
    int d;
    xs = '{mk(0, 7, 0, 0), mk(0, 0, 4, 0), mk(0, 0, 4, 0)};
    as = '{mk(1, 2, 3, 4), mk(1, 2, 3, 4), mk(9, 8, 42, 6)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 3) begin bad++; $display("FAIL switch_done_at got=%0d want=3", d); end
    total++; if (winner_idx !== 2'd2 || iter_count !== 3'd3 || status !== 2'b00 || winner_data !== 32'd42) begin
      bad++; $display("FAIL switch_fields got idx=%0d it=%0d st=%b dat=%0d want 2 3 00 42",
                      winner_idx, iter_count, status, winner_data);
    end
    accept();
  endtask

  task automatic test_timeout;
    bus_t xs[$], as[$];
    int d;
    xs = '{mk(1, 2, 0, 0), mk(3, 0, 3, 0), mk(0, 1, 1, 1), mk(4, 4, 4, 4), mk(0, 5, 6, 0)};
    as = '{mk(1, 1, 1, 1), mk(2, 2, 2, 2), mk(3, 3, 3, 3), mk(4, 4, 4, 4), mk(50, 51, 52, 53)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 5) begin bad++; $display("FAIL tmo_done_at got=%0d want=5", d); end
    total++; if (status !== 2'b10 || iter_count !== 3'd5 || winner_idx !== 2'd1 || winner_data !== 32'd51) begin
      bad++; $display("FAIL tmo_fields got st=%b it=%0d idx=%0d dat=%0d want 10 5 1 51",
                      status, iter_count, winner_idx, winner_data);
    end
    accept();
    xs = '{mk(1, 1, 0, 0), mk(1, 1, 0, 0), mk(1, 1, 0, 0), mk(0, 0, 0, 9), mk(0, 0, 0, 9)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 5 || status !== 2'b00 || winner_idx !== 2'd3 || iter_count !== 3'd5) begin
      bad++; $display("FAIL tmo_stable got done=%0d st=%b idx=%0d it=%0d want 5 00 3 5",
                      d, status, winner_idx, iter_count);
    end
    accept();
  endtask

  task automatic test_backpressure;
    bus_t xs[$], as[$];
    int d, errs;
    xs = '{mk(5, 3, 0, 0), mk(2, 0, 0, 0), mk(1, 0, 0, 0)};
    as = '{mk(11, 12, 13, 14), mk(21, 22, 23, 24), mk(31, 32, 33, 34)};
    run_seq(xs, as, 1'b0, d);
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      start = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      x_bus = mk(0, 0, 0, 0);
      a_bus = {$urandom, $urandom, $urandom, $urandom};
      step();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || winner_idx !== 2'd0 || winner_data !== 32'd31 ||
          status !== 2'b00 || iter_count !== 3'd3) begin
        bad++;
        $display("FAIL hold_cycle%0d got ov=%b ir=%b idx=%0d dat=%0d st=%b it=%0d want 1 0 0 31 00 3",
                 c, out_valid, in_ready, winner_idx, winner_data, status, iter_count);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    accept();
  endtask

  task automatic test_back_to_back;
    bus_t xs[$], as[$];
    int d;
    out_ready = 1'b1;
    xs = '{mk(0, 0, 8, 0), mk(0, 0, 8, 0)};
    as = '{mk(1, 2, 3, 4), mk(5, 6, 66, 8)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 2 || winner_data !== 32'd66) begin
      bad++; $display("FAIL b2b_first got done=%0d dat=%0d want 2 66", d, winner_data);
    end
    step();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_one_cycle got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    xs = '{mk(0, 0, 0, 0)};
    as = '{mk(90, 91, 92, 93)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 1 || status !== 2'b01 || winner_data !== 32'd90) begin
      bad++; $display("FAIL b2b_second got done=%0d st=%b dat=%0d want 1 01 90", d, status, winner_data);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun;
    bus_t xs[$], as[$];
    int d;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL start_ready got ir=%b busy=%b want 1 1", in_ready, busy);
    end
    in_valid = 1'b1;
    x_bus = mk(0, 3, 0, 0);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    xs = '{mk(5, 3, 0, 0), mk(2, 0, 0, 0), mk(1, 0, 0, 0)};
    as = '{mk(11, 12, 13, 14), mk(21, 22, 23, 24), mk(31, 32, 33, 34)};
    run_seq(xs, as, 1'b0, d);
    total++; if (d !== 3 || winner_idx !== 2'd0 || iter_count !== 3'd3 || status !== 2'b00) begin
      bad++; $display("FAIL rst_rerun got done=%0d idx=%0d it=%0d st=%b want 3 0 3 00",
                      d, winner_idx, iter_count, status);
    end
    accept();
  endtask

  task automatic test_random;
    bus_t xs[$], as[$];
    bus_t xv;
    int d, en, est, eidx, r;
    logic [31:0] edat;
    for (int t = 0; t < 40; t++) begin
      xs = {};
      as = {};
      for (int k = 0; k < MAX_ITER; k++) begin
        for (int c = 0; c < N; c++) begin
          r = $urandom_range(0, 9);
          xv[c*W +: W] = (r < 5) ? 32'd0 : (r == 5) ? 32'h8000_0000 :
                         (32'($urandom_range(1, 255)) | (r == 9 ? 32'h8000_0000 : 32'd0));
        end
        xs.push_back(xv);
        as.push_back({$urandom, $urandom, $urandom, $urandom});
      end
      model(xs, as, en, est, eidx, edat);
      run_seq(xs, as, 1'b1, d);
      total++;
      if (d !== en || status !== 2'(est) || winner_idx !== 2'(eidx) || winner_data !== edat ||
          iter_count !== 3'(en) || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d got done=%0d st=%b idx=%0d dat=%h it=%0d ir=%b want %0d %0d %0d %h %0d 0",
                 t, d, status, winner_idx, winner_data, iter_count, in_ready, en, est, eidx, edat, en);
      end
      repeat ($urandom_range(0, 2)) step();
      accept();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_converge();
    test_ignore_sign();
    test_all_zero();
    test_switch();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
